// File: rtl/clk_rst_pkg.sv
// Shared types and defaults for the clock-enable / reset generator.
package clk_rst_pkg;

    localparam int DIVW_DEF = 16;

    typedef logic [DIVW_DEF-1:0] div_t;

    // Per-channel architectural state at the default divisor width.
    typedef struct packed {
        div_t cnt;
        div_t active;
        div_t pending;
        logic pend;
    } ch_state_t;

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: down-counter, shadow divisor register, tick and
// square-wave outputs. Divisor updates are applied only at a period boundary.
module clk_div_ch
    import clk_rst_pkg::*;
#(
    parameter int DIVW    = DIVW_DEF,
    parameter int DIV_RST = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [DIVW-1:0] i_div,
    input  logic            i_load,
    input  logic            i_en,
    output logic            o_tick,
    output logic            o_clk,
    output logic            o_pend
);

    typedef struct packed {
        logic [DIVW-1:0] cnt;
        logic [DIVW-1:0] active;
        logic [DIVW-1:0] pending;
        logic            pend;
    } st_t;

    localparam logic [DIVW-1:0] DIV_INIT = DIVW'(DIV_RST);
    localparam logic [DIVW-1:0] ONE      = DIVW'(1);

    st_t  r_st;
    logic r_tick;
    logic r_clk;

    // Count down; at zero emit a tick, toggle clk and reload from the
    // pending divisor if one is waiting, otherwise from the active one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st   <= '{cnt: '0, active: DIV_INIT, pending: '0, pend: 1'b0};
            r_tick <= 1'b0;
            r_clk  <= 1'b0;
        end else if (i_load && !i_en) begin
            // Stopped channel: take the new divisor immediately.
            r_st.active <= i_div;
            r_st.cnt    <= '0;
            r_st.pend   <= 1'b0;
            r_tick      <= 1'b0;
        end else if (i_en) begin
            if (r_st.cnt == '0) begin
                r_tick <= 1'b1;
                r_clk  <= ~r_clk;
                if (r_st.pend) begin
                    r_st.cnt    <= r_st.pending;
                    r_st.active <= r_st.pending;
                    r_st.pend   <= 1'b0;
                end else begin
                    r_st.cnt <= r_st.active;
                end
            end else begin
                r_st.cnt <= r_st.cnt - ONE;
                r_tick   <= 1'b0;
            end
            // A load on a boundary edge lands in pending for the next one;
            // a later load in the same period overwrites an earlier one.
            if (i_load) begin
                r_st.pending <= i_div;
                r_st.pend    <= 1'b1;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign o_tick = r_tick;
    assign o_clk  = r_clk;
    assign o_pend = r_st.pend;

endmodule

// File: rtl/clk_rst_gen.sv
// Top: sequenced system reset (async assert, synchronised + stretched
// deassert) and NCH independently programmable divider channels.
module clk_rst_gen
    import clk_rst_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int DIVW     = DIVW_DEF,
    parameter int DIV_RST  = 0,
    parameter int RST_HOLD = 16
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NCH-1:0][DIVW-1:0]  div_i,
    input  logic [NCH-1:0]            div_load_i,
    input  logic [NCH-1:0]            en_i,
    output logic [NCH-1:0]            tick_o,
    output logic [NCH-1:0]            clk_o,
    output logic [NCH-1:0]            pend_o,
    output logic                      sys_resetn_o
);

    localparam int              HW       = $clog2(RST_HOLD + 1);
    localparam logic [HW-1:0]   HOLD_MAX = HW'(RST_HOLD);

    logic [1:0]    r_sync;
    logic [HW-1:0] r_hold;
    logic          r_sys;
    logic          w_sys_rstn;

    // Synchronise board reset release, then hold for RST_HOLD cycles before
    // releasing the system reset; board reset assertion clears everything.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync <= 2'b00;
            r_hold <= '0;
            r_sys  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], 1'b1};
            if (r_sync[1] && (r_hold != HOLD_MAX))
                r_hold <= r_hold + HW'(1);
            r_sys <= (r_hold == HOLD_MAX);
        end
    end

    assign w_sys_rstn   = r_sys;
    assign sys_resetn_o = r_sys;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        clk_div_ch #(
            .DIVW    (DIVW),
            .DIV_RST (DIV_RST)
        ) u_ch (
            .clk    (clk),
            .rst_n  (w_sys_rstn),
            .i_div  (div_i[c]),
            .i_load (div_load_i[c]),
            .i_en   (en_i[c]),
            .o_tick (tick_o[c]),
            .o_clk  (clk_o[c]),
            .o_pend (pend_o[c])
        );
    end

endmodule

// File: doc/clk_rst_gen.md
# clk_rst_gen

Parametrised clock-enable and reset generator; the successor to the single-channel free-running divider. Produces NCH independently programmable tick/divided-clock channels with glitch-free runtime divisor updates, and a sequenced system reset (async assert, synchronised and stretched deassert) for the rest of the design. Sits at the top level between the board clock/reset pins and all core logic.

## Interface
- NCH, 2, number of divider channels (1..8)
- DIVW, 16, divisor width per channel
- DIV_RST, 0, divisor value every channel holds out of reset
- RST_HOLD, 16, cycles sys_resetn_o is held low after synchronised deassertion (≥1)

- clk  in  1  board clock; single clock domain
- resetn  in  1  board reset, asynchronous, active-low
- div_i  in  NCH×DIVW  requested divisor D per channel
- div_load_i  in  NCH  one-cycle strobe: capture div_i[c]
- en_i  in  NCH  channel run enable
- tick_o  out  NCH  one-cycle pulse every D+1 enabled cycles
- clk_o  out  NCH  square output, toggles on every tick (period 2(D+1))
- pend_o  out  NCH  divisor captured, not yet applied
- sys_resetn_o  out  1  sequenced active-low reset for the design

## Operation
- Reset sequencer: resetn low → sys_resetn_o low asynchronously, same instant. Deassertion passes a 2-flop synchroniser, then a hold counter counts RST_HOLD cycles; sys_resetn_o rises when the counter saturates. resetn re-asserted mid-hold clears synchroniser and counter; sequence restarts.
- Channels held in reset while sys_resetn_o low: cnt=0, active divisor=DIV_RST, pending empty, tick_o=0, clk_o=0, pend_o=0.
- Per channel, each edge with en_i=1 and released: if cnt==0 → tick_o<=1, clk_o<=~clk_o, cnt<=next divisor; else cnt<=cnt-1, tick_o<=0.
- Next divisor = pending value if pend_o set (pending then consumed, pend_o<=0), else active divisor. Updates therefore take effect only at a period boundary: no truncated/stretched period.
- div_load_i with en_i=1: div_i captured into pending, pend_o<=1; second load before boundary overwrites pending (last wins).
- div_load_i with en_i=0: div_i written directly to active, cnt<=0, pend_o<=0.
- en_i=0: cnt, clk_o frozen, tick_o<=0. Re-enable resumes count from frozen cnt.
- D=0: tick_o constantly high, clk_o = clk/2. D=2^DIVW−1: maximum period, no overflow (cnt never exceeds DIVW bits).
- Load coincident with boundary (cnt==0, en_i=1): the loaded value goes to pending for the following boundary; boundary uses prior next-divisor.

## Timing
- All outputs registered except async assertion of sys_resetn_o.
- resetn rising before edge 0: sys_resetn_o high after edge 2+RST_HOLD.
- First tick_o: high in the cycle after the first enabled edge with sys_resetn_o high (cnt=0 out of reset).
- Steady state: tick_o period D+1 cycles, duty 1/(D+1); clk_o period 2(D+1).
- Divisor change latency: applied at next tick; pend_o clears on that same edge.

## Structure
- Package clk_rst_pkg: DIVW default, div_t typedef, channel state struct (cnt, active, pending, pend flag).
- Sub-module clk_div_ch: one channel (counter, shadow register, tick/clk_o), instantiated NCH times via generate.
- Reset sequencer (synchroniser + hold counter) inline in clk_rst_gen.

## Test plan
- resetn low 5 cycles, release, RST_HOLD=16 → sys_resetn_o low through edge 17, high after edge 18; all tick_o/clk_o/pend_o 0 until then.
- resetn re-asserted at hold count 8 → sys_resetn_o stays low, full 18-cycle sequence restarts after release.
- Ch0 D=3 loaded while disabled, en_i=1 → tick_o pulse every 4 cycles, clk_o period 8; ch1 D=0 → tick_o continuous, clk_o toggles every cycle.
- Ch0 running D=3, load D=7 mid-period → pend_o=1, current 4-cycle period completes, pend_o clears, next ticks every 8 cycles.
- en_i dropped at cnt=2 for 10 cycles → no ticks, clk_o held; re-enable → tick after 3 enabled cycles.
- Load at exact boundary cycle, and two loads (5 then 9) in one period → boundary uses old divisor/9 respectively; never a short period.
